instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/riscv_pkg.sv | 13 +
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch-stage state encoding.
package riscv_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/instruction_fetch.sv
// Single-entry fetch stage: registers {pc, instruction} for decode, halts on
// ECALL/EBREAK or an illegal fetch, and restarts on a redirect.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_out_valid, w_out_valid_nxt;
  logic [31:0]  r_out_pc, w_out_pc_nxt;
  logic [31:0]  r_out_instr, w_out_instr_nxt;
  logic         r_out_fault, w_out_fault_nxt;

  logic         w_transfer;
  logic         w_illegal;
  logic [32:0]  w_last_byte;

  // Widened so the end-of-word address cannot wrap past IMEM_BYTES.
  assign w_last_byte = {1'b0, r_pc} + 33'd3;
  assign w_illegal   = (w_last_byte >= 33'(IMEM_BYTES)) || (r_pc[1:0] != 2'b00);
  assign w_transfer  = r_out_valid && out_ready && !redirect_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_instr_nxt = r_out_instr;
    w_out_fault_nxt = r_out_fault;

    if (redirect_valid) begin
      w_pc_nxt        = redirect_pc;
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_out_valid || w_transfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_pc_nxt    = r_pc;
            if (w_illegal) begin
              w_out_instr_nxt = INSN_NOP;
              w_out_fault_nxt = 1'b1;
              w_state_nxt     = HALTED;
            end else begin
              w_out_instr_nxt = instruction;
              w_out_fault_nxt = 1'b0;
              w_pc_nxt        = r_pc + 32'd4;
              if (instruction == INSN_ECALL || instruction == INSN_EBREAK) begin
                w_state_nxt = HALTED;
              end
            end
          end
        end
        HALTED: begin
          if (w_transfer) begin
            w_out_valid_nxt = 1'b0;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_fault <= w_out_fault_nxt;
    end
  end

  assign pc        = r_pc;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_instr;
  assign out_fault = r_out_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory
// and a queue of words expected to cross the decode handshake.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] mem [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign instruction = (pc < 32'd1024) ? mem[pc[9:2]] : 32'hDEAD_BEEF;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instruction   (instruction),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_fault     (out_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic f);
    xfer_t e;
    e.pc = p; e.instr = i; e.fault = f;
    exp_q.push_back(e);
  endtask

  // One clock: score any handshake at the falling edge, then step past the rising edge.
  task automatic cyc();
    xfer_t e;
    @(negedge clk);
    if (out_valid && out_ready && !redirect_valid && !rst) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL xfer_unexpected: observed pc %h expected no transfer", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", out_pc, e.pc);
        chk("xfer_instr", out_instr, e.instr);
        chk("xfer_fault", {31'd0, out_fault}, {31'd0, e.fault});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[0]   = 32'h1111_1111;
    mem[1]   = 32'h2222_2222;
    mem[2]   = 32'h3333_3333;
    mem[3]   = 32'h4444_4444;
    mem[4]   = 32'h0000_0073;
    mem[16]  = 32'h0400_0093;
    mem[255] = 32'hCAFE_0013;

    // Reset asserted together with a redirect: reset wins.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_fault", {31'd0, out_fault}, 32'd0);

    // Straight line with a three-cycle stall at 0x4, ending on ECALL at 0x10.
    redirect_valid = 1'b0;
    push(32'h0,  32'h1111_1111, 1'b0);
    push(32'h4,  32'h2222_2222, 1'b0);
    push(32'h8,  32'h3333_3333, 1'b0);
    push(32'hC,  32'h4444_4444, 1'b0);
    push(32'h10, 32'h0000_0073, 1'b0);
    rst = 1'b0;
    cyc();
    chk("first_out_pc", out_pc, 32'h0);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", pc, 32'h4);
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_out_pc", out_pc, 32'h4);
      chk("stall_out_instr", out_instr, 32'h2222_2222);
      chk("stall_pc", pc, 32'h8);
    end
    out_ready = 1'b1;
    cyc();
    chk("resume_out_pc", out_pc, 32'h8);
    cyc(); cyc();
    chk("ecall_instr", out_instr, 32'h0000_0073);
    chk("ecall_fault", {31'd0, out_fault}, 32'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("halted_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("q_empty_a", 32'(exp_q.size()), 32'd0);

    // Redirect out of HALTED, then redirect over a stalled word.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cyc();
    chk("redir0_valid", {31'd0, out_valid}, 32'd0);
    chk("redir0_pc", pc, 32'h0);
    redirect_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk("resume0_out_pc", out_pc, 32'h0);
    chk("resume0_valid", {31'd0, out_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    chk("redir40_valid", {31'd0, out_valid}, 32'd0);
    chk("redir40_pc", pc, 32'h40);
    redirect_valid = 1'b0;
    cyc();
    chk("redir40_out_pc", out_pc, 32'h40);
    chk("redir40_out_instr", out_instr, 32'h0400_0093);

    // Last legal word, then an out-of-range fetch, then a misaligned one.
    redirect_valid = 1'b1; redirect_pc = 32'd1020;
    cyc();
    redirect_valid = 1'b0; out_ready = 1'b1;
    push(32'd1020, 32'hCAFE_0013, 1'b0);
    push(32'd1024, 32'h0000_0013, 1'b1);
    cyc();
    chk("edge_out_pc", out_pc, 32'd1020);
    chk("edge_fault", {31'd0, out_fault}, 32'd0);
    chk("edge_pc", pc, 32'd1024);
    cyc();
    chk("oob_instr", out_instr, 32'h0000_0013);
    chk("oob_fault", {31'd0, out_fault}, 32'd1);
    chk("oob_pc_held", pc, 32'd1024);
    cyc(); cyc();
    chk("oob_halted_valid", {31'd0, out_valid}, 32'd0);
    chk("oob_halted_pc", pc, 32'd1024);
    redirect_valid = 1'b1; redirect_pc = 32'h2;
    cyc();
    redirect_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk("mis_out_pc", out_pc, 32'h2);
    chk("mis_fault", {31'd0, out_fault}, 32'd1);
    chk("mis_instr", out_instr, 32'h0000_0013);
    chk("mis_pc_held", pc, 32'h2);

    // Reset while a word is stalled discards it.
    rst = 1'b1;
    cyc();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_pc", out_pc, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    push(32'h0, 32'h1111_1111, 1'b0);
    cyc(); cyc();
    chk("q_empty_b", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
